// File: rtl/fp32_pkg.sv
// Shared single-precision definitions for the multi-cycle FP datapath units
// (divider and multiplier). Holds the sequencer state encoding, the exponent
// type and constants, and the IEEE-754 field positions.
package fp32_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_SPECIAL,
      ST_NORM_A,
      ST_NORM_B,
      ST_DIV_INIT,
      ST_DIV,
      ST_DIV_DONE,
      ST_NORM_1,
      ST_NORM_2,
      ST_ROUND,
      ST_PACK,
      ST_OUTPUT
   } fp_state_e;

   localparam int          EXP_BIAS    = 127;
   localparam int          EMIN        = -126;
   localparam logic [31:0] NAN_PATTERN = 32'hFFC00000;
   localparam logic [31:0] POS_INF     = 32'h7F800000;

   // IEEE-754 single field positions
   localparam int SIGN_BIT = 31;
   localparam int EXP_HI   = 30;
   localparam int EXP_LO   = 23;
   localparam int FRAC_HI  = 22;
   localparam int FRAC_LO  = 0;

   // Unbiased exponent, two's complement; wide enough for a_e - b_e of
   // fully normalised denormals (-149 - 127 .. 127 + 149).
   typedef logic signed [9:0] exp_t;

   localparam exp_t EXP_BIAS_E = exp_t'(EXP_BIAS);
   localparam exp_t EMIN_E     = exp_t'(EMIN);
   localparam exp_t EMAX_E     = exp_t'(EXP_BIAS);
   localparam exp_t E_INF_NAN  = exp_t'(EXP_BIAS + 1);  // biased field 255
   localparam exp_t E_ZERO_DEN = exp_t'(-EXP_BIAS);     // biased field 0

endpackage

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider, one quotient bit per clock.
// Computes quot = floor(dividend_m * 2^(QUOT_BITS-1) / divisor_m) and the
// matching remainder. Both mantissas must be normalised (bit 23 set), which
// keeps the partial remainder below 2*divisor at every step.
//   clk, rst_n  : clock, async active-low reset
//   start       : load operands and clear the bit counter
//   dividend_m  : 24b dividend mantissa
//   divisor_m   : 24b divisor mantissa
//   done        : high in the cycle whose clock edge resolves the last bit;
//                 quot/rem are final from the following cycle
//   quot        : quotient bits
//   rem         : true remainder (25b)
module fp_mant_divider #(
   parameter int QUOT_BITS = 27
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [23:0]          dividend_m,
   input  logic [23:0]          divisor_m,
   output logic                 done,
   output logic [QUOT_BITS-1:0] quot,
   output logic [24:0]          rem
);

   logic                 busy_q, busy_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [24:0]          rem_q, rem_d;
   logic [23:0]          dvs_q, dvs_d;
   logic [QUOT_BITS-1:0] quot_q, quot_d;

   logic [25:0]          diff;
   logic [24:0]          rem_sel;
   logic                 ge;
   logic                 last;

   always_comb begin
      diff    = {1'b0, rem_q} - {2'b00, dvs_q};
      ge      = ~diff[25];
      rem_sel = ge ? diff[24:0] : rem_q;
      last    = busy_q && (cnt_q == 5'(QUOT_BITS - 1));

      busy_d  = busy_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;

      if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         rem_d  = {1'b0, dividend_m};
         dvs_d  = divisor_m;
         quot_d = '0;
      end else if (busy_q) begin
         quot_d = {quot_q[QUOT_BITS-2:0], ge};
         // rem_sel < divisor < 2^24, so the doubled value still fits.
         // The stored remainder is therefore always 2x the true one.
         rem_d  = rem_sel << 1;
         cnt_d  = cnt_q + 5'd1;
         if (last) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         quot_q <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         quot_q <= quot_d;
      end
   end

   assign done = last;
   assign quot = quot_q;
   assign rem  = {1'b0, rem_q[24:1]};

endmodule

// File: rtl/fpdivider_fsm.sv
// Iterative IEEE-754 single-precision divider, z = a / b, round-to-nearest-
// even with full denormal support. Special operands resolve in 2 cycles;
// finite operands go through normalise / restoring divide / round / pack.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (ready only when idle)
//   input_a, input_b    : dividend, divisor
//   out_valid/out_ready : result handshake; result held until accepted
//   output_z            : quotient
module fpdivider_fsm #(
   parameter int          QUOT_BITS   = 27,
   parameter logic [31:0] NAN_PATTERN = fp32_pkg::NAN_PATTERN
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] input_a,
   input  logic [31:0] input_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] output_z
);

   import fp32_pkg::*;

   fp_state_e   state_q, state_d;
   logic [31:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;
   logic [23:0] a_m_q, a_m_d, b_m_q, b_m_d;
   exp_t        a_e_q, a_e_d, b_e_q, b_e_d;
   logic        a_s_q, a_s_d, b_s_q, b_s_d;
   logic [23:0] z_m_q, z_m_d;
   exp_t        z_e_q, z_e_d;
   logic        z_s_q, z_s_d;
   logic        g_q, g_d, r_q, r_d, s_q, s_d;
   logic [31:0] out_z_q, out_z_d;

   logic                 div_start, div_done;
   logic [QUOT_BITS-1:0] div_quot;
   logic [24:0]          div_rem;

   logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
   logic [7:0] pack_exp;

   // Classification on unpacked fields (fraction only, hidden bit not set yet)
   assign a_nan  = (a_e_q == E_INF_NAN)  && (a_m_q != '0);
   assign b_nan  = (b_e_q == E_INF_NAN)  && (b_m_q != '0);
   assign a_inf  = (a_e_q == E_INF_NAN)  && (a_m_q == '0);
   assign b_inf  = (b_e_q == E_INF_NAN)  && (b_m_q == '0);
   assign a_zero = (a_e_q == E_ZERO_DEN) && (a_m_q == '0);
   assign b_zero = (b_e_q == E_ZERO_DEN) && (b_m_q == '0);
   assign sgn    = a_s_q ^ b_s_q;

   fp_mant_divider #(.QUOT_BITS(QUOT_BITS)) u_mdiv (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (div_start),
      .dividend_m (a_m_q),
      .divisor_m  (b_m_q),
      .done       (div_done),
      .quot       (div_quot),
      .rem        (div_rem)
   );

   always_comb begin
      state_d   = state_q;
      a_raw_d   = a_raw_q;
      b_raw_d   = b_raw_q;
      a_m_d     = a_m_q;
      b_m_d     = b_m_q;
      a_e_d     = a_e_q;
      b_e_d     = b_e_q;
      a_s_d     = a_s_q;
      b_s_d     = b_s_q;
      z_m_d     = z_m_q;
      z_e_d     = z_e_q;
      z_s_d     = z_s_q;
      g_d       = g_q;
      r_d       = r_q;
      s_d       = s_q;
      out_z_d   = out_z_q;
      div_start = 1'b0;
      pack_exp  = '0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_raw_d = input_a;
               b_raw_d = input_b;
               state_d = ST_UNPACK;
            end
         end

         ST_UNPACK: begin
            a_m_d   = {1'b0, a_raw_q[FRAC_HI:FRAC_LO]};
            b_m_d   = {1'b0, b_raw_q[FRAC_HI:FRAC_LO]};
            a_e_d   = exp_t'({2'b00, a_raw_q[EXP_HI:EXP_LO]}) - EXP_BIAS_E;
            b_e_d   = exp_t'({2'b00, b_raw_q[EXP_HI:EXP_LO]}) - EXP_BIAS_E;
            a_s_d   = a_raw_q[SIGN_BIT];
            b_s_d   = b_raw_q[SIGN_BIT];
            state_d = ST_SPECIAL;
         end

         ST_SPECIAL: begin
            state_d = ST_OUTPUT;
            if (a_nan || b_nan)
               out_z_d = NAN_PATTERN;
            else if (a_inf)
               out_z_d = (b_inf || b_zero) ? NAN_PATTERN : {sgn, POS_INF[30:0]};
            else if (b_inf)
               out_z_d = {sgn, 31'd0};
            else if (a_zero)
               out_z_d = b_zero ? NAN_PATTERN : {sgn, 31'd0};
            else if (b_zero)
               out_z_d = {sgn, POS_INF[30:0]};
            else begin
               // Denormals live at EMIN without a hidden bit
               if (a_e_q == E_ZERO_DEN) a_e_d = EMIN_E;
               else                     a_m_d[23] = 1'b1;
               if (b_e_q == E_ZERO_DEN) b_e_d = EMIN_E;
               else                     b_m_d[23] = 1'b1;
               state_d = ST_NORM_A;
            end
         end

         ST_NORM_A: begin
            if (!a_m_q[23]) begin
               a_m_d = {a_m_q[22:0], 1'b0};
               a_e_d = a_e_q - 10'sd1;
            end else
               state_d = ST_NORM_B;
         end

         ST_NORM_B: begin
            if (!b_m_q[23]) begin
               b_m_d = {b_m_q[22:0], 1'b0};
               b_e_d = b_e_q - 10'sd1;
            end else
               state_d = ST_DIV_INIT;
         end

         ST_DIV_INIT: begin
            z_s_d     = sgn;
            z_e_d     = a_e_q - b_e_q;
            div_start = 1'b1;
            state_d   = ST_DIV;
         end

         ST_DIV: begin
            if (div_done) state_d = ST_DIV_DONE;
         end

         ST_DIV_DONE: begin
            z_m_d   = div_quot[QUOT_BITS-1 -: 24];
            g_d     = div_quot[2];
            r_d     = div_quot[1];
            s_d     = div_quot[0] | (div_rem != '0);
            state_d = ST_NORM_1;
         end

         // Quotient of two normalised mantissas is in [0.5, 2): at most one
         // left shift is ever needed here.
         ST_NORM_1: begin
            if (!z_m_q[23]) begin
               z_m_d = {z_m_q[22:0], g_q};
               g_d   = r_q;
               r_d   = 1'b0;
               z_e_d = z_e_q - 10'sd1;
            end else
               state_d = ST_NORM_2;
         end

         // Denormalise results below EMIN, collecting lost bits into sticky
         ST_NORM_2: begin
            if (z_e_q < EMIN_E) begin
               z_m_d = z_m_q >> 1;
               z_e_d = z_e_q + 10'sd1;
               g_d   = z_m_q[0];
               r_d   = g_q;
               s_d   = s_q | r_q;
            end else
               state_d = ST_ROUND;
         end

         ST_ROUND: begin
            if (g_q && (r_q || s_q || z_m_q[0])) begin
               z_m_d = z_m_q + 24'd1;
               // Mantissa wraps to zero; the bumped exponent restores the value
               if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
            end
            state_d = ST_ROUND == ST_ROUND ? ST_PACK : ST_PACK;
         end

         ST_PACK: begin
            pack_exp = z_e_q[7:0] + 8'(EXP_BIAS);
            if ((z_e_q == EMIN_E) && !z_m_q[23]) pack_exp = '0;
            if (z_e_q > EMAX_E) out_z_d = {z_s_q, POS_INF[30:0]};
            else                out_z_d = {z_s_q, pack_exp, z_m_q[22:0]};
            state_d = ST_OUTPUT;
         end

         ST_OUTPUT: begin
            if (out_ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_raw_q <= '0;
         b_raw_q <= '0;
         a_m_q   <= '0;
         b_m_q   <= '0;
         a_e_q   <= '0;
         b_e_q   <= '0;
         a_s_q   <= 1'b0;
         b_s_q   <= 1'b0;
         z_m_q   <= '0;
         z_e_q   <= '0;
         z_s_q   <= 1'b0;
         g_q     <= 1'b0;
         r_q     <= 1'b0;
         s_q     <= 1'b0;
         out_z_q <= '0;
      end else begin
         state_q <= state_d;
         a_raw_q <= a_raw_d;
         b_raw_q <= b_raw_d;
         a_m_q   <= a_m_d;
         b_m_q   <= b_m_d;
         a_e_q   <= a_e_d;
         b_e_q   <= b_e_d;
         a_s_q   <= a_s_d;
         b_s_q   <= b_s_d;
         z_m_q   <= z_m_d;
         z_e_q   <= z_e_d;
         z_s_q   <= z_s_d;
         g_q     <= g_d;
         r_q     <= r_d;
         s_q     <= s_d;
         out_z_q <= out_z_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_OUTPUT);
   assign output_z  = out_z_q;

endmodule

// File: tb/tb_fpdivider_fsm.sv
// Self-checking bench for fpdivider_fsm: directed spec vectors with latency
// checks, back-pressure, mid-operation reset, then random operands checked
// against an exact integer-arithmetic IEEE-754 division model.
module tb_fpdivider_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] output_z;

   int n_chk  = 0;
   int n_pass = 0;

   fpdivider_fsm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .input_a   (input_a),
      .input_b   (input_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .output_z  (output_z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // Exact reference: value = m * 2^e for each operand, long integer divide
   // with 60 extra fraction bits, then round-to-nearest-even at the lsb
   // weight of the target format (2^(E-23) normal, 2^-149 denormal).
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, half, sticky;
      logic [127:0] ma, mb, q, r, mant, lowbits;
      int           ea, eb, p, e_res, lsb, sh;
      longint       total;
      s      = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      a_zero = (a[30:0] == 0);
      b_zero = (b[30:0] == 0);
      if (a_nan || b_nan) return 32'hFFC00000;
      if (a_inf) return (b_inf || b_zero) ? 32'hFFC00000 : {s, 8'hFF, 23'd0};
      if (b_inf) return {s, 31'd0};
      if (a_zero) return b_zero ? 32'hFFC00000 : {s, 31'd0};
      if (b_zero) return {s, 8'hFF, 23'd0};
      ma = {104'd0, (a[30:23] != 0), a[22:0]};
      mb = {104'd0, (b[30:23] != 0), b[22:0]};
      ea = (a[30:23] == 0) ? -149 : int'(a[30:23]) - 150;
      eb = (b[30:23] == 0) ? -149 : int'(b[30:23]) - 150;
      q  = (ma << 60) / mb;
      r  = (ma << 60) % mb;
      p  = 127;
      while (p > 0 && !q[p]) p--;
      e_res = p + ea - eb - 60;
      lsb   = (e_res < -126) ? -149 : e_res - 23;
      sh    = lsb - (ea - eb - 60);
      if (sh > 120) begin
         mant = 0; half = 1'b0; sticky = 1'b1;
      end else begin
         mant    = q >> sh;
         half    = q[sh-1];
         lowbits = q & ((128'd1 << (sh - 1)) - 128'd1);
         sticky  = (lowbits != 0) || (r != 0);
      end
      if (half && (sticky || mant[0])) mant = mant + 128'd1;
      total = longint'((e_res < -126) ? 0 : e_res + 126) * 64'sd8388608 + longint'(mant[24:0]);
      if (total >= 64'sd255 * 64'sd8388608) return {s, 8'hFF, 23'd0};
      return {s, 31'(total)};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] v;
      int          k;
      v = $urandom;
      k = $urandom_range(0, 15);
      case (k)
         0:       v[30:23] = 8'h00;
         1:       v[30:0]  = '0;
         2: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = '0; end
         3, 4:    v[30:23] = 8'($urandom_range(1, 24));
         5, 6:    v[30:23] = 8'($urandom_range(228, 254));
         default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
      return v;
   endfunction

   // One transaction; exp_lat < 0 skips the latency check, hold = cycles of
   // back-pressure applied once the result is up.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_z, input int exp_lat, input int hold);
      int          lat;
      logic [31:0] z0;
      lat = 0;
      while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
      if (!in_ready) begin chk({tag, ":in_ready"}, 32'(in_ready), 1); return; end
      input_a  = a;
      input_b  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      input_a  = $urandom;
      input_b  = $urandom;
      lat = 0;
      while (!out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
      if (!out_valid) begin chk({tag, ":timeout"}, 32'(out_valid), 1); return; end
      chk(tag, output_z, exp_z);
      if (exp_lat >= 0) chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
      z0 = output_z;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, ":hold_z"}, output_z, z0);
         chk({tag, ":hold_rdy"}, 32'(in_ready), 0);
         chk({tag, ":hold_vld"}, 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ":post_vld"}, 32'(out_valid), 0);
      chk({tag, ":post_rdy"}, 32'(in_ready), 1);
   endtask

   initial begin
      logic [31:0] a, b;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      input_a   = '0;
      input_b   = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_output_z", output_z, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 37, 0);
      run_op("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 38, 0);
      run_op("1/0",       32'h3F800000, 32'h00000000, 32'h7F800000, 2, 0);
      run_op("0/0",       32'h00000000, 32'h00000000, 32'hFFC00000, 2, 0);
      run_op("-1/inf",    32'hBF800000, 32'h7F800000, 32'h80000000, 2, 0);
      run_op("nan/1",     32'h7FC00001, 32'h3F800000, 32'hFFC00000, 2, 0);
      run_op("ovf",       32'h7F7FFFFF, 32'h00800000, 32'h7F800000, -1, 0);
      run_op("den_res",   32'h00800000, 32'h40000000, 32'h00400000, 38, 0);
      run_op("den_in",    32'h00000001, 32'h3F000000, 32'h00000002, 82, 0);

      // Back-pressure then back-to-back operations
      run_op("bp_1/3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 38, 10);
      run_op("b2b_6/2",   32'h40C00000, 32'h40000000, 32'h40400000, 37, 0);
      run_op("b2b_-6/2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 37, 0);

      // Reset in the middle of the divide loop
      input_a  = 32'h40C00000;
      input_b  = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("mid_div_vld", 32'(out_valid), 0);
      rst_n = 1'b0;
      #1;
      chk("abort_vld", 32'(out_valid), 0);
      chk("abort_z", output_z, 0);
      chk("abort_rdy", 32'(in_ready), 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst_6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 37, 0);

      for (int i = 0; i < 200; i++) begin
         a = rnd_fp();
         b = rnd_fp();
         run_op($sformatf("rand %08h/%08h", a, b), a, b, ref_div(a, b), -1, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fpdivider_fsm.md
Name: fpdivider_fsm

Overview:
- Iterative IEEE-754 single-precision divider; computes z = a / b.
- Inverse-operation companion to the team's multi-cycle FP multiplier in the processor datapath.
- Same unpack / special-case / normalise / round / pack flow as the multiplier, with restoring mantissa division in place of the multiply.
- Adds valid/ready handshakes on both input and output, so the execute stage can stall cleanly.

Parameters:
- QUOT_BITS, 27, quotient bits produced (24 mantissa + guard + round + 1 sticky-carrying bit); one bit per cycle.
- NAN_PATTERN, 32'hFFC00000, canonical NaN returned for every NaN result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  divider idle, accepts operands
- input_a  input  32  dividend, IEEE-754 single
- input_b  input  32  divisor, IEEE-754 single
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- output_z  output  32  quotient, IEEE-754 single

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, output_z=0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- in_ready=1 only in IDLE. The operands are captured on the edge where in_valid&&in_ready, and the state moves to UNPACK.
- UNPACK:
  - a_m/b_m = fraction (24b, bit23 = 0).
  - a_e/b_e = exp−127 (10b signed).
  - Signs are captured.
- SPECIAL: priority order, result goes direct to OUTPUT:
  - (1) a or b NaN → NAN_PATTERN.
  - (2) a inf: if b is inf or zero → NAN_PATTERN, else inf with sign a_s^b_s.
  - (3) b inf → signed zero.
  - (4) a zero: if b zero → NAN_PATTERN, else signed zero.
  - (5) b zero → signed inf.
  - Otherwise: a denormal (e=−127) → e=−126; a normal → set m[23]. Same for b. Go to NORM_A.
- NORM_A / NORM_B: while m[23]==0, shift m left 1 and decrement e, one shift per cycle. When m[23] is set, advance.
- DIV_INIT:
  - z_s=a_s^b_s.
  - z_e=a_e−b_e.
  - Load the divider.
  - Clear the bit counter.
- DIV: restoring division, one quotient bit per cycle for QUOT_BITS cycles. Produces Q=floor(a_m·2^26 / b_m) and remainder R. Q lies in [2^25, 2^27).
- DIV_DONE:
  - z_m=Q[26:3], guard=Q[2], round=Q[1].
  - sticky=Q[0] | (R≠0).
- NORM_1: if z_m[23]==0:
  - shift z_m left with guard into bit0;
  - guard←round, round←0;
  - z_e−1.
  - At most one shift occurs.
- NORM_2: while z_e < −126:
  - z_m>>1, z_e+1;
  - guard←z_m[0], round←guard, sticky|=round.
- ROUND:
  - Round-to-nearest-even: increment if guard&&(round|sticky|z_m[0]).
  - If z_m==24'hFFFFFF before the increment, z_e+1.
- PACK:
  - exp=z_e[7:0]+127.
  - exp=0 if z_e==−126 && z_m[23]==0 (denormal).
  - If z_e>127 → signed inf.
- OUTPUT:
  - out_valid=1 and output_z stable until out_valid&&out_ready.
  - On that edge, out_valid←0 and state←IDLE; in_ready is high the following cycle.
  - No new operand is accepted in the same cycle as result handoff.
- Latency from the accept edge to out_valid high:
  - special cases: 2 cycles;
  - normal operands with a normal result: 37 cycles, or 38 when NORM_1 shifts;
  - denormal inputs add 1 cycle per NORM_A/NORM_B shift;
  - denormal results add 1 cycle per NORM_2 shift.
- Internal widths:
  - exponents 10b two's complement;
  - division remainder 25b;
  - counter 5b.
- Back-pressure: out_ready low holds OUTPUT indefinitely, with output_z unchanged.

Decomposition:
- Shared package fp32_pkg, containing:
  - the state enumeration;
  - EXP_BIAS=127, EMIN=−126;
  - NAN_PATTERN, POS_INF=32'h7F800000;
  - field slice constants (sign 31, exp 30:23, frac 22:0).
- The multiplier adopts the same package.
- One sub-module: fp_mant_divider.
  - Ports: start, dividend mantissa, divisor mantissa, done, Q, R.
  - Contains the restoring loop and counter.
  - Independently testable against integer division.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000, out_valid exactly 37 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, checks round-up; 38-cycle latency.
- Specials, each 2-cycle latency:
  - 0x3F800000/0x00000000 → 0x7F800000;
  - 0x00000000/0x00000000 → 0xFFC00000;
  - 0xBF800000/0x7F800000 → 0x80000000;
  - 0x7FC00001/0x3F800000 → 0xFFC00000.
- Range limits:
  - 0x7F7FFFFF/0x00800000 → 0x7F800000 (overflow);
  - 0x00800000/0x40000000 → 0x00400000 (denormal result);
  - 0x00000001/0x3F000000 → 0x00000002 (denormal input).
- Handshake: hold out_ready=0 for 10 cycles after out_valid → output_z stable, in_ready=0. Then release → in_ready=1 next cycle, and back-to-back ops give correct results.
- Reset: assert rst_n=0 at cycle 15 of a DIV → out_valid=0, output_z=0, in_ready=1 immediately. A following 6/2 returns 0x40400000.
